// File: rtl/drop_timer.sv
// Gravity timer: counts divider ticks against a level-dependent period and
// raises a held drop request for the game FSM. Drops that fall due while a
// request is still pending are tallied in a saturating missed counter.
module drop_timer #(
    parameter int unsigned BASE_PERIOD = 16,
    parameter int unsigned SOFT_PERIOD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_n,
    input  logic       enable,
    input  logic       pause,
    input  logic       soft_drop,
    input  logic [3:0] level,
    input  logic       cnt_clr,
    input  logic       drop_ack,
    output logic       drop_req,
    output logic [3:0] missed,
    output logic [4:0] tick_cnt
);

    typedef enum logic [1:0] {
        StOff,
        StRun,
        StPend
    } state_e;

    localparam logic [4:0] BasePer = 5'(BASE_PERIOD);
    localparam logic [4:0] SoftPer = 5'(SOFT_PERIOD);

    state_e     state;
    logic [4:0] period;
    logic [5:0] cnt_inc;
    logic       tick_valid;
    logic       drop_event;

    // Period select: soft drop wins, high levels clamp to one tick per drop.
    always_comb begin
        period = BasePer - {1'b0, level};
        if (soft_drop) begin
            period = SoftPer;
        end else if ({1'b0, level} >= (BasePer - 5'd1)) begin
            period = 5'd1;
        end
    end

    // Tick qualification and period-complete detection. The compare is done
    // at 6 bits and uses >= so a period that shrinks mid-count fires at once.
    always_comb begin
        cnt_inc    = {1'b0, tick_cnt} + 6'd1;
        tick_valid = !tick_n && enable && !pause && !cnt_clr && (state != StOff);
        drop_event = tick_valid && (cnt_inc >= {1'b0, period});
    end

    // Main FSM with registered drop_req, missed and tick_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StOff;
            drop_req <= 1'b0;
            missed   <= 4'd0;
            tick_cnt <= 5'd0;
        end else if (!enable) begin
            state    <= StOff;
            drop_req <= 1'b0;
            missed   <= 4'd0;
            tick_cnt <= 5'd0;
        end else begin
            // Tick counter; cnt_clr swallows any same-cycle tick.
            if (cnt_clr) begin
                tick_cnt <= 5'd0;
            end else if (tick_valid) begin
                tick_cnt <= drop_event ? 5'd0 : cnt_inc[4:0];
            end

            unique case (state)
                StOff: begin
                    state    <= StRun;
                    drop_req <= 1'b0;
                end
                StRun: begin
                    if (drop_event) begin
                        state    <= StPend;
                        drop_req <= 1'b1;
                    end
                end
                StPend: begin
                    if (drop_event) begin
                        // A coincident ack retires the old request while the
                        // new event re-arms it, so nothing is lost.
                        if (!drop_ack && (missed != 4'd15)) begin
                            missed <= missed + 4'd1;
                        end
                    end else if (drop_ack) begin
                        state    <= StRun;
                        drop_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= StOff;
                    drop_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_timer.sv
// Directed self-checking bench for drop_timer (BASE_PERIOD=16, SOFT_PERIOD=1).
module tb_drop_timer;

    logic       clk;
    logic       rst;
    logic       tick_n;
    logic       enable;
    logic       pause;
    logic       soft_drop;
    logic [3:0] level;
    logic       cnt_clr;
    logic       drop_ack;
    logic       drop_req;
    logic [3:0] missed;
    logic [4:0] tick_cnt;

    int total = 0;
    int bad   = 0;

    drop_timer #(
        .BASE_PERIOD(16),
        .SOFT_PERIOD(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_n   (tick_n),
        .enable   (enable),
        .pause    (pause),
        .soft_drop(soft_drop),
        .level    (level),
        .cnt_clr  (cnt_clr),
        .drop_ack (drop_ack),
        .drop_req (drop_req),
        .missed   (missed),
        .tick_cnt (tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_n = 1'b0;
        step();
        tick_n = 1'b1;
    endtask

    // Drop enable for one cycle, then bring the block back to RUN with cleared state.
    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic ack();
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_n = 1'b1; enable = 1'b0; pause = 1'b0; soft_drop = 1'b0;
        level = 4'd0; cnt_clr = 1'b0; drop_ack = 1'b0;
        step();
        step();
        total++;
        if ({drop_req, missed, tick_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_vals: got req=%b missed=%0d cnt=%0d want 0/0/0",
                     drop_req, missed, tick_cnt);
        end
        rst = 1'b0;
        step();
        // Enable rising with a tick in the same cycle: that tick is not counted.
        enable = 1'b1;
        tick_n = 1'b0;
        step();
        tick_n = 1'b1;
        total++;
        if (tick_cnt !== 5'd0 || drop_req !== 1'b0) begin
            bad++;
            $display("FAIL enable_tick_ignored: got cnt=%0d req=%b want 0/0", tick_cnt, drop_req);
        end
    endtask

    task automatic test_base_period();
        restart();
        level = 4'd0;
        for (int round = 0; round < 2; round++) begin
            for (int i = 1; i <= 16; i++) begin
                do_tick();
                total++;
                if (tick_cnt !== 5'(i % 16) || drop_req !== (i == 16)) begin
                    bad++;
                    $display("FAIL base_tick%0d_r%0d: got cnt=%0d req=%b want cnt=%0d req=%b",
                             i, round, tick_cnt, drop_req, i % 16, (i == 16));
                end
                repeat (3) step();
            end
            ack();
            total++;
            if (drop_req !== 1'b0) begin
                bad++;
                $display("FAIL base_ack_r%0d: got req=%b want 0", round, drop_req);
            end
        end
    endtask

    task automatic test_level_soft();
        restart();
        level = 4'd15;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            total++;
            if (drop_req !== 1'b1 || tick_cnt !== 5'd0) begin
                bad++;
                $display("FAIL level15_tick%0d: got req=%b cnt=%0d want 1/0", i, drop_req, tick_cnt);
            end
            ack();
        end
        restart();
        level = 4'd5;
        for (int i = 1; i <= 11; i++) begin
            do_tick();
            total++;
            if (tick_cnt !== 5'(i % 11) || drop_req !== (i == 11)) begin
                bad++;
                $display("FAIL level5_tick%0d: got cnt=%0d req=%b want cnt=%0d req=%b",
                         i, tick_cnt, drop_req, i % 11, (i == 11));
            end
        end
        ack();
        restart();
        level = 4'd0;
        repeat (7) do_tick();
        soft_drop = 1'b1;
        do_tick();
        soft_drop = 1'b0;
        total++;
        if (drop_req !== 1'b1 || tick_cnt !== 5'd0) begin
            bad++;
            $display("FAIL soft_drop: got req=%b cnt=%0d want 1/0", drop_req, tick_cnt);
        end
        ack();
    endtask

    task automatic test_missed();
        restart();
        level = 4'd15;
        for (int i = 1; i <= 20; i++) begin
            do_tick();
            total++;
            if (drop_req !== 1'b1 || missed !== 4'((i - 1 > 15) ? 15 : i - 1)) begin
                bad++;
                $display("FAIL missed_tick%0d: got req=%b missed=%0d want 1/%0d",
                         i, drop_req, missed, (i - 1 > 15) ? 15 : i - 1);
            end
        end
        enable = 1'b0;
        step();
        total++;
        if (drop_req !== 1'b0 || missed !== 4'd0) begin
            bad++;
            $display("FAIL missed_disable: got req=%b missed=%0d want 0/0", drop_req, missed);
        end
        enable = 1'b1;
        step();
    endtask

    task automatic test_ack_event();
        restart();
        level = 4'd15;
        do_tick();
        drop_ack = 1'b1;
        tick_n = 1'b0;
        step();
        drop_ack = 1'b0;
        tick_n = 1'b1;
        total++;
        if (drop_req !== 1'b1 || missed !== 4'd0) begin
            bad++;
            $display("FAIL ack_with_event: got req=%b missed=%0d want 1/0", drop_req, missed);
        end
        ack();
        total++;
        if (drop_req !== 1'b0 || missed !== 4'd0) begin
            bad++;
            $display("FAIL ack_alone: got req=%b missed=%0d want 0/0", drop_req, missed);
        end
    endtask

    task automatic test_pause_clr();
        restart();
        level = 4'd0;
        repeat (9) do_tick();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            total++;
            if (tick_cnt !== 5'd9 || drop_req !== 1'b0) begin
                bad++;
                $display("FAIL pause_tick%0d: got cnt=%0d req=%b want 9/0", i, tick_cnt, drop_req);
            end
        end
        pause = 1'b0;
        // Period shrinks below the current count: fires on the next tick.
        level = 4'd15;
        do_tick();
        total++;
        if (drop_req !== 1'b1 || tick_cnt !== 5'd0) begin
            bad++;
            $display("FAIL shrink_fire: got req=%b cnt=%0d want 1/0", drop_req, tick_cnt);
        end
        pause = 1'b1;
        tick_n = 1'b0;
        ack();
        tick_n = 1'b1;
        total++;
        if (drop_req !== 1'b0 || missed !== 4'd0) begin
            bad++;
            $display("FAIL pause_ack: got req=%b missed=%0d want 0/0", drop_req, missed);
        end
        pause = 1'b0;
        level = 4'd0;
        repeat (3) do_tick();
        level = 4'd15;
        cnt_clr = 1'b1;
        tick_n = 1'b0;
        step();
        cnt_clr = 1'b0;
        tick_n = 1'b1;
        total++;
        if (tick_cnt !== 5'd0 || drop_req !== 1'b0) begin
            bad++;
            $display("FAIL clr_with_tick: got cnt=%0d req=%b want 0/0", tick_cnt, drop_req);
        end
    endtask

    task automatic test_reset_mid();
        restart();
        level = 4'd15;
        repeat (4) do_tick();
        level = 4'd0;
        repeat (2) do_tick();
        total++;
        if (drop_req !== 1'b1 || missed !== 4'd3 || tick_cnt !== 5'd2) begin
            bad++;
            $display("FAIL pre_rst: got req=%b missed=%0d cnt=%0d want 1/3/2",
                     drop_req, missed, tick_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (drop_req !== 1'b0 || missed !== 4'd0 || tick_cnt !== 5'd0) begin
            bad++;
            $display("FAIL async_rst: got req=%b missed=%0d cnt=%0d want 0/0/0",
                     drop_req, missed, tick_cnt);
        end
        rst = 1'b0;
        step();
        do_tick();
        total++;
        if (tick_cnt !== 5'd1 || drop_req !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_count: got cnt=%0d req=%b want 1/0", tick_cnt, drop_req);
        end
    endtask

    initial begin
        test_reset();
        test_base_period();
        test_level_soft();
        test_missed();
        test_ack_event();
        test_pause_clr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
